csr_file: RTL
=============

# csr_file

Machine-mode CSR file for the single-cycle core: a parametrised successor to the fixed four-register CSR block. It adds XLEN-generic storage, atomic trap entry and `mret` handling, CSR read-modify-write ops, hardware counters, and illegal-access detection. It sits beside the integer register file and is read in decode/execute. It is written at end of cycle by the CSR instruction path and the trap/mret controller.

## Interface
- `XLEN`, 32: data width; legal values are 32 and 64.
- `MTVEC_RESET`, 0x8000_0000: reset value of mtvec.
- `HART_ID`, 0: value returned by mhartid.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset; one clock, and reset is asynchronous and active-high.
- `raddr` in 12: CSR read/RMW address.
- `rdata` out XLEN: combinational read of `raddr`, showing the pre-write value.
- `csr_op` in 2: CSR operation.
  - 00: none.
  - 01: write.
  - 10: set (old | wdata).
  - 11: clear (old & ~wdata).
- `csr_wdata` in XLEN: operand for `csr_op`; the target is `raddr`.
- `csr_illegal` out 1: combinational; asserted when `raddr` is unimplemented, or when `csr_op`≠00 and `raddr[11:10]`==2'b11.
- `trap_valid` in 1: take a trap this cycle.
- `trap_pc` in XLEN: faulting PC.
- `trap_cause` in XLEN: cause; MSB is the interrupt flag.
- `trap_tval` in XLEN: mtval value.
- `mret_valid` in 1: execute `mret` this cycle.
- `retire` in 1: one instruction retired this cycle.
- `trap_vector` out XLEN: combinational trap target.
- `mepc_o` out XLEN: current mepc, used as the `mret` target.
- `mie_o` out 1: mstatus.MIE.

## Operation
- Address map:
  - 0x300 mstatus.
  - 0x301 misa: read-only; MXL per XLEN, I bit set.
  - 0x305 mtvec.
  - 0x340 mscratch.
  - 0x341 mepc.
  - 0x342 mcause.
  - 0x343 mtval.
  - 0xF11 mvendorid: reads 0.
  - 0xF12 marchid: reads 0.
  - 0xF14 mhartid: reads `HART_ID`.
  - Counters: see Configuration.
  - Any other address: `rdata`=0 and `csr_illegal`=1.
- mstatus bits:
  - Only MIE[3] and MPIE[7] are writable.
  - MPP[12:11] is hardwired to 2'b11.
  - All other bits read 0.
  - Reset value is 0x0000_1800.
- WARL rules:
  - mepc[1:0] always reads 0.
  - mtvec[1] always reads 0.
  - mtvec[0] selects the mode: 0 is direct, 1 is vectored.
- Trap vector:
  - Direct mode: `{mtvec[XLEN-1:2],2'b00}`.
  - Vectored mode with `trap_cause` MSB=1: base + 4·cause[XLEN-2:0] (modulo 2^XLEN).
  - Otherwise: the base.
- Trap entry, when `trap_valid`=1, updates in one edge:
  - mepc ← `trap_pc` with [1:0] cleared.
  - mcause ← `trap_cause`.
  - mtval ← `trap_tval`.
  - MPIE ← MIE, then MIE ← 0.
- `mret`: MIE ← MPIE, MPIE ← 1.
- Priority when events coincide:
  - trap > mret > csr_op; the lower-priority write is dropped entirely.
  - The counter increment is independent of this priority.
- An illegal `csr_op` (`csr_illegal`=1) modifies no state.
- Writes to read-only or unimplemented addresses are dropped.

## Timing
- Reads are zero latency, combinational from `raddr`.
- Writes become visible to `rdata` on the cycle after the edge that commits them.
- Read-during-write returns the old value, so RMW ops use the pre-edge value.
- Reset values:
  - mstatus 0x1800.
  - mtvec `MTVEC_RESET`.
  - mscratch, mepc, mcause, mtval and all counters: 0.
- Outputs during reset:
  - `mie_o`=0.
  - `mepc_o`=0.
  - `trap_vector`=`MTVEC_RESET` with [1:0] masked.
- Reset asserted mid-trap aborts the update, and all state immediately takes its reset values.
- `trap_valid` and `mret_valid` are single-cycle pulses; holding either high for N cycles re-applies the update N times.

## Configuration
- `CSR_COUNTERS_EN` defined: the counters are implemented.
  - mcycle 0xB00 and minstret 0xB02, each 64 bits.
  - For XLEN=32 only, upper halves mcycleh 0xB80 and minstreth 0xB82. For XLEN=64 these addresses are illegal.
  - mcycle increments every cycle out of reset.
  - minstret increments when `retire`=1.
  - Both wrap from 2^64−1 to 0.
  - A CSR write to any counter half loads that half with the written value. That counter does not increment on that edge; the other half is preserved.
- `CSR_COUNTERS_EN` undefined: no counter storage exists; all counter addresses read 0 with `csr_illegal`=1.

## Test plan
- Reset then read 0x300, 0x305 and 0x301 → 0x1800, `MTVEC_RESET` and 0x4000_0100 (XLEN=32); `csr_illegal`=0.
- Write 0x305=0x1000_0001, then trap with cause 0x8000_0007 → `trap_vector`=0x1000_001C; a trap with cause 2 gives 0x1000_0000.
- Set MIE (op 10, 0x8), then trap with pc 0x8000_0103 → mepc=0x8000_0100, MIE=0, MPIE=1; then `mret` → MIE=1, MPIE=1.
- `trap_valid`, `mret_valid` and a write of mscratch=0xDEAD asserted together → only the trap updates; mscratch is unchanged.
- Write 0xF14 or read 0x7C0 → `csr_illegal`=1 and no state change.
- With `CSR_COUNTERS_EN`:
  - Write mcycle=0xFFFF_FFFF → mcycle reads 0xFFFF_FFFF for one cycle; after one further edge mcycle=0 and mcycleh has incremented by 1.
  - 3 `retire` pulses → minstret increases by 3.

Source files
------------

// File: rtl/csr_file.sv
// Machine-mode CSR file: WARL storage, trap entry/mret, CSR read-modify-write ops.
// Optional 64-bit mcycle/minstret counters are built when CSR_COUNTERS_EN is defined.
module csr_file #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = XLEN'(32'h8000_0000),
  parameter logic [XLEN-1:0] HART_ID     = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     raddr,
  output logic [XLEN-1:0] rdata,
  input  logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_wdata,
  output logic            csr_illegal,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_valid,
  input  logic            retire,
  output logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] mepc_o,
  output logic            mie_o
);

  localparam logic [1:0]      MXL        = (XLEN == 64) ? 2'd2 : 2'd1;
  localparam logic [XLEN-1:0] MISA_VAL   = {MXL, {(XLEN-2){1'b0}}} | XLEN'(32'h0000_0100);
  localparam logic [XLEN-1:0] MTVEC_WARL = {MTVEC_RESET[XLEN-1:2], 1'b0, MTVEC_RESET[0]};

  logic            mie_q, mie_d, mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [XLEN-1:0] mstatus_s, rdata_s, wval_s, base_s;
  logic            impl_s, csr_we_s;
  logic            unused_s;
`ifdef CSR_COUNTERS_EN
  logic [63:0]     mcycle_q, mcycle_d, minstret_q, minstret_d;
  assign unused_s = ^trap_pc[1:0];
`else
  assign unused_s = ^{trap_pc[1:0], retire};
`endif

  assign mstatus_s = XLEN'({2'b11, 3'b000, mpie_q, 3'b000, mie_q, 3'b000});

  // Read decode: value of raddr and whether it is implemented.
  always_comb begin
    rdata_s = '0;
    impl_s  = 1'b1;
    case (raddr)
      12'h300: rdata_s = mstatus_s;
      12'h301: rdata_s = MISA_VAL;
      12'h305: rdata_s = mtvec_q;
      12'h340: rdata_s = mscratch_q;
      12'h341: rdata_s = mepc_q;
      12'h342: rdata_s = mcause_q;
      12'h343: rdata_s = mtval_q;
      12'hF11: rdata_s = '0;
      12'hF12: rdata_s = '0;
      12'hF14: rdata_s = HART_ID;
`ifdef CSR_COUNTERS_EN
      12'hB00: rdata_s = mcycle_q[XLEN-1:0];
      12'hB02: rdata_s = minstret_q[XLEN-1:0];
      12'hB80: if (XLEN == 32) rdata_s = XLEN'(mcycle_q[63:32]); else impl_s = 1'b0;
      12'hB82: if (XLEN == 32) rdata_s = XLEN'(minstret_q[63:32]); else impl_s = 1'b0;
`endif
      default: impl_s = 1'b0;
    endcase
  end

  assign rdata       = rdata_s;
  assign csr_illegal = !impl_s || ((csr_op != 2'b00) && (raddr[11:10] == 2'b11));
  assign csr_we_s    = (csr_op != 2'b00) && !csr_illegal;
  assign mepc_o      = mepc_q;
  assign mie_o       = mie_q;

  // RMW operand built from the pre-edge read value.
  always_comb begin
    case (csr_op)
      2'b01:   wval_s = csr_wdata;
      2'b10:   wval_s = rdata_s | csr_wdata;
      2'b11:   wval_s = rdata_s & ~csr_wdata;
      default: wval_s = rdata_s;
    endcase
  end

  // Trap target; vectored offset only for interrupts, masked base while in reset.
  always_comb begin
    base_s = {mtvec_q[XLEN-1:2], 2'b00};
    if (rst) begin
      trap_vector = {MTVEC_RESET[XLEN-1:2], 2'b00};
    end else if (mtvec_q[0] && trap_cause[XLEN-1]) begin
      trap_vector = base_s + {trap_cause[XLEN-3:0], 2'b00};
    end else begin
      trap_vector = base_s;
    end
  end

  // Next state: trap wins over mret, which wins over the CSR op.
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
`ifdef CSR_COUNTERS_EN
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, retire};
`endif
    if (trap_valid) begin
      mepc_d   = {trap_pc[XLEN-1:2], 2'b00};
      mcause_d = trap_cause;
      mtval_d  = trap_tval;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret_valid) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (csr_we_s) begin
      case (raddr)
        12'h300: begin
          mie_d  = wval_s[3];
          mpie_d = wval_s[7];
        end
        12'h305: mtvec_d    = {wval_s[XLEN-1:2], 1'b0, wval_s[0]};
        12'h340: mscratch_d = wval_s;
        12'h341: mepc_d     = {wval_s[XLEN-1:2], 2'b00};
        12'h342: mcause_d   = wval_s;
        12'h343: mtval_d    = wval_s;
`ifdef CSR_COUNTERS_EN
        // A written counter half holds the new value instead of counting.
        12'hB00: begin
          mcycle_d = mcycle_q;
          mcycle_d[XLEN-1:0] = wval_s;
        end
        12'hB02: begin
          minstret_d = minstret_q;
          minstret_d[XLEN-1:0] = wval_s;
        end
        12'hB80: begin
          mcycle_d = mcycle_q;
          mcycle_d[63:32] = wval_s[31:0];
        end
        12'hB82: begin
          minstret_d = minstret_q;
          minstret_d[63:32] = wval_s[31:0];
        end
`endif
        default: mie_d = mie_q;
      endcase
    end else begin
      mie_d = mie_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_WARL;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
`ifdef CSR_COUNTERS_EN
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
`endif
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
`ifdef CSR_COUNTERS_EN
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
`endif
    end
  end

endmodule
